shift_sequencer: RTL and testbench

//  Multi-cycle barrel-shift controller for the 16-bit datapath. It performs a

---
 rtl/shift_sequencer_if.sv | 17 +
 rtl/shift_sequencer.sv | 107 ++++++++++
 tb/tb_shift_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Start/done handshake bundle between a shift requester and shift_sequencer.
// The requester drives the operands; the sequencer returns status and result.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;

  modport master (output start, op, a, shamt, input  busy, done, y);
  modport slave  (input  start, op, a, shamt, output busy, done, y);
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle logical/arithmetic shifter: each cycle shifts the captured operand
// by 2, with one final shift by 1 for odd amounts, then pulses done with the result.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_rem;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_y;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [SHW-1:0]   w_rem_nxt;
  logic [1:0]       w_op_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_done_nxt;
  logic             w_step2;
  logic [WIDTH-1:0] w_shifted;

  // Op 2'b11 is reserved and falls into the SLL branch.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       op,
    input logic             two
  );
    logic fill;
    fill = (op == OP_SRA) ? v[WIDTH-1] : 1'b0;
    unique case (op)
      OP_SRL, OP_SRA: shift_step = two ? {{2{fill}}, v[WIDTH-1:2]} : {fill, v[WIDTH-1:1]};
      default:        shift_step = two ? {v[WIDTH-3:0], 2'b00}     : {v[WIDTH-2:0], 1'b0};
    endcase
  endfunction

  assign w_step2   = (r_rem >= SHW'(2));
  assign w_shifted = shift_step(r_acc, r_op, w_step2);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_op_nxt    = r_op;
    w_y_nxt     = r_y;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_acc_nxt   = bus.a;
          w_rem_nxt   = bus.shamt;
          w_op_nxt    = bus.op;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_rem == '0) begin
          w_y_nxt     = r_acc;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_acc_nxt = w_shifted;
          w_rem_nxt = w_step2 ? (r_rem - SHW'(2)) : '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_op    <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_op    <= w_op_nxt;
      r_y     <= w_y_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = r_done;
  assign bus.y    = r_y;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus random
// operations compared against a plain-arithmetic shift and latency model.
module tb_shift_sequencer;
  localparam int WIDTH = 16;
  localparam int SHW   = 4;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [WIDTH-1:0] exp_y;
  int               exp_lat;
  int               busy_cnt;

  shift_sequencer_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                 input int s);
    logic signed [WIDTH-1:0] sa;
    sa = a;
    case (op)
      2'b01:   return a >> s;
      2'b10:   return sa >>> s;
      default: return a << s;
    endcase
  endfunction

  function automatic int ref_latency(input int s);
    return (s + 1) / 2 + 1;
  endfunction

  // Called #1 after an edge; the following edge accepts the request.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input int s);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.shamt = SHW'(s);
    exp_y     = ref_shift(op, a, s);
    exp_lat   = ref_latency(s);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.op    = 2'($urandom);
    bus.shamt = SHW'($urandom);
    check("busy_after_accept", bus.busy, 1'b1);
    check("done_low_after_accept", bus.done, 1'b0);
    busy_cnt = bus.busy ? 1 : 0;
  endtask

  // poke > 0 raises start (with a fresh operand) for one cycle while busy.
  task automatic wait_done(input int poke);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busy_cnt++;
        if (n == poke) begin
          bus.start = 1'b1;
          bus.a     = WIDTH'($urandom);
          bus.shamt = SHW'($urandom);
        end
      end
    end
    check("done_seen", seen, 1'b1);
    check("latency", n, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("busy_low_in_done", bus.busy, 1'b0);
    check("result", bus.y, exp_y);
  endtask

  task automatic idle_hold_check();
    @(posedge clk);
    #1;
    check("done_one_cycle", bus.done, 1'b0);
    check("y_held", bus.y, exp_y);
    check("idle_not_busy", bus.busy, 1'b0);
  endtask

  initial begin
    int seen_done;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 16'h1234;
    bus.shamt = 4'd3;

    // Reset held with start asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_y", bus.y, 16'h0000);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    check("rst_not_accepted", bus.busy, 1'b0);

    issue(2'b00, 16'h0001, 15);
    wait_done(0);
    check("sll15_lit", bus.y, 16'h8000);
    idle_hold_check();

    issue(2'b10, 16'h8000, 3);
    wait_done(0);
    check("sra3_lit", bus.y, 16'hF000);
    idle_hold_check();
    issue(2'b01, 16'h8000, 3);
    wait_done(0);
    check("srl3_lit", bus.y, 16'h1000);
    idle_hold_check();

    for (int op = 0; op < 4; op++) begin
      issue(2'(op), 16'hBEEF, 0);
      wait_done(0);
      check("shamt0_lit", bus.y, 16'hBEEF);
      idle_hold_check();
    end
    issue(2'b00, 16'h00FF, 1);
    wait_done(0);
    check("sll1_lit", bus.y, 16'h01FE);
    idle_hold_check();

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(2'b00, 16'h1234, 9);
    wait_done(2);
    check("poke_ignored_lit", bus.y, 16'h6800);
    issue(2'b11, 16'h0F0F, 5);
    wait_done(0);
    check("b2b_lit", bus.y, 16'hE1E0);
    idle_hold_check();

    // Abort mid-SHIFT.
    issue(2'b10, 16'h8001, 12);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_y", bus.y, 16'h0000);
    check("abort_done", bus.done, 1'b0);
    seen_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_idle", bus.busy, 1'b0);

    // Random operations, mixing back-to-back and gapped issue.
    for (int k = 0; k < 60; k++) begin
      issue(2'($urandom), WIDTH'($urandom), int'($urandom_range(0, WIDTH - 1)));
      wait_done(($urandom_range(0, 3) == 0) ? 1 : 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) idle_hold_check();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
